tracker_sequencer: RTL and testbench

TRACKER_SEQUENCER -- requirements
Module: tracker_sequencer

---
 rtl/tracker_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_tracker_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tracker_sequencer.sv
// Two-axis solar tracker sequencer: samples four photoresistors through a shared ADC,
// then drives the vertical and horizontal motors one at a time until both axes balance.
module tracker_sequencer #(
  parameter int DEADBAND      = 5,
  parameter int MOVE_CYCLES   = 50000,
  parameter int SETTLE_CYCLES = 10000,
  parameter int ACK_TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        adc_req,
  output logic [1:0]  adc_ch,
  input  logic        adc_ack,
  input  logic [15:0] adc_data,
  output logic [1:0]  s_out_theta,
  output logic [1:0]  s_out_phi,
  output logic        busy,
  output logic        locked,
  output logic        adc_err
);

  typedef enum logic [2:0] {IDLE, SAMPLE, EVAL, MOVE_T, MOVE_P, SETTLE} state_t;

  localparam logic [1:0] MOT_STOP = 2'b00;
  localparam logic [1:0] MOT_CW   = 2'b01;
  localparam logic [1:0] MOT_CCW  = 2'b11;

  // One shared counter serves ACK waiting, motor drive and settling.
  localparam int MAX_MS  = (MOVE_CYCLES > SETTLE_CYCLES) ? MOVE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_MAX = (MAX_MS > ACK_TIMEOUT) ? MAX_MS : ACK_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] MOVE_LAST   = CNT_W'(MOVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACK_LAST    = CNT_W'(ACK_TIMEOUT - 1);

  state_t            state, state_n;
  logic              req_n;
  logic [1:0]        ch_n;
  logic [1:0]        theta_n, phi_n;
  logic              locked_n, err_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [15:0]       samples   [4];
  logic [15:0]       samples_n [4];
  logic              enable_d;

  logic [16:0] diff_v, diff_h;
  logic        bal_v, bal_h;
  logic [1:0]  dir_v, dir_h;

  // Sample registers stay frozen through the motion phases, so evaluation results are live.
  assign diff_v = (samples[0] > samples[1]) ? ({1'b0, samples[0]} - {1'b0, samples[1]})
                                            : ({1'b0, samples[1]} - {1'b0, samples[0]});
  assign diff_h = (samples[2] > samples[3]) ? ({1'b0, samples[2]} - {1'b0, samples[3]})
                                            : ({1'b0, samples[3]} - {1'b0, samples[2]});
  assign bal_v  = (diff_v <= 17'(DEADBAND));
  assign bal_h  = (diff_h <= 17'(DEADBAND));
  assign dir_v  = (samples[0] > samples[1]) ? MOT_CW : MOT_CCW;
  assign dir_h  = (samples[2] > samples[3]) ? MOT_CW : MOT_CCW;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      adc_req     <= 1'b0;
      adc_ch      <= 2'd0;
      s_out_theta <= MOT_STOP;
      s_out_phi   <= MOT_STOP;
      locked      <= 1'b0;
      adc_err     <= 1'b0;
      cnt         <= '0;
      enable_d    <= 1'b0;
      for (int i = 0; i < 4; i++) samples[i] <= '0;
    end else begin
      state       <= state_n;
      adc_req     <= req_n;
      adc_ch      <= ch_n;
      s_out_theta <= theta_n;
      s_out_phi   <= phi_n;
      locked      <= locked_n;
      adc_err     <= err_n;
      cnt         <= cnt_n;
      enable_d    <= enable;
      for (int i = 0; i < 4; i++) samples[i] <= samples_n[i];
    end
  end

  // Motors default to stop every cycle, so an enable drop silences them on the next edge.
  always_comb begin
    state_n   = state;
    req_n     = adc_req;
    ch_n      = adc_ch;
    theta_n   = MOT_STOP;
    phi_n     = MOT_STOP;
    locked_n  = locked;
    err_n     = adc_err;
    cnt_n     = cnt;
    samples_n = samples;

    if (enable && !enable_d) err_n = 1'b0;

    case (state)
      IDLE: begin
        if (enable && !adc_err) begin
          state_n = SAMPLE;
          req_n   = 1'b1;
          ch_n    = 2'd0;
          cnt_n   = '0;
        end
      end

      SAMPLE: begin
        if (adc_req) begin
          // An outstanding request always finishes, even after enable drops.
          if (adc_ack) begin
            samples_n[adc_ch] = adc_data;
            req_n = 1'b0;
            ch_n  = adc_ch + 2'd1;
            cnt_n = '0;
            if (!enable)               state_n = IDLE;
            else if (adc_ch == 2'd3)   state_n = EVAL;
          end else if (cnt == ACK_LAST) begin
            req_n    = 1'b0;
            err_n    = 1'b1;
            locked_n = 1'b0;
            cnt_n    = '0;
            state_n  = IDLE;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end else if (!enable) begin
          state_n = IDLE;
        end else begin
          req_n = 1'b1;
          cnt_n = '0;
        end
      end

      EVAL: begin
        if (!enable) begin
          state_n = IDLE;
        end else begin
          locked_n = bal_v && bal_h;
          cnt_n    = '0;
          if (bal_v && bal_h) begin
            state_n = SAMPLE;
            req_n   = 1'b1;
            ch_n    = 2'd0;
          end else if (!bal_v) begin
            state_n = MOVE_T;
            theta_n = dir_v;
          end else begin
            state_n = MOVE_P;
            phi_n   = dir_h;
          end
        end
      end

      MOVE_T: begin
        if (!enable) begin
          state_n = IDLE;
        end else if (cnt == MOVE_LAST) begin
          cnt_n = '0;
          if (!bal_h) begin
            state_n = MOVE_P;
            phi_n   = dir_h;
          end else begin
            state_n = SETTLE;
          end
        end else begin
          cnt_n   = cnt + CNT_W'(1);
          theta_n = dir_v;
        end
      end

      MOVE_P: begin
        if (!enable) begin
          state_n = IDLE;
        end else if (cnt == MOVE_LAST) begin
          cnt_n   = '0;
          state_n = SETTLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
          phi_n = dir_h;
        end
      end

      SETTLE: begin
        if (!enable) begin
          state_n = IDLE;
        end else if (cnt == SETTLE_LAST) begin
          cnt_n   = '0;
          state_n = SAMPLE;
          req_n   = 1'b1;
          ch_n    = 2'd0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tracker_sequencer.sv
// Directed bench for tracker_sequencer with short timing parameters; the initial block
// plays the ADC and checks every output against hand-computed values.
module tb_tracker_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        adc_req;
  logic [1:0]  adc_ch;
  logic        adc_ack;
  logic [15:0] adc_data;
  logic [1:0]  s_out_theta;
  logic [1:0]  s_out_phi;
  logic        busy;
  logic        locked;
  logic        adc_err;

  int checks = 0;
  int errors = 0;

  tracker_sequencer #(
    .DEADBAND      (5),
    .MOVE_CYCLES   (4),
    .SETTLE_CYCLES (3),
    .ACK_TIMEOUT   (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .adc_req     (adc_req),
    .adc_ch      (adc_ch),
    .adc_ack     (adc_ack),
    .adc_data    (adc_data),
    .s_out_theta (s_out_theta),
    .s_out_phi   (s_out_phi),
    .busy        (busy),
    .locked      (locked),
    .adc_err     (adc_err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic en, input logic ack, input logic [15:0] data);
    enable   = en;
    adc_ack  = ack;
    adc_data = data;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic check_motors(input string tag, input logic [1:0] theta, input logic [1:0] phi);
    check_output({tag, "_theta"}, s_out_theta, theta);
    check_output({tag, "_phi"}, s_out_phi, phi);
  endtask

  // Bounded wait for a request, then a one-cycle ack carrying the given reading.
  task automatic sample_channel(input logic [1:0] ch, input logic [15:0] data);
    int waited = 0;
    while (!adc_req && waited < 6) begin
      tick();
      waited++;
    end
    check_output($sformatf("req_ch%0d", ch), adc_req, 1);
    check_output($sformatf("adc_ch%0d", ch), adc_ch, ch);
    apply_stimulus(enable, 1'b1, data);
    tick();
    apply_stimulus(enable, 1'b0, 16'd0);
    check_output($sformatf("req_drop_ch%0d", ch), adc_req, 0);
  endtask

  task automatic sample_four(input logic [15:0] d0, input logic [15:0] d1,
                             input logic [15:0] d2, input logic [15:0] d3);
    sample_channel(2'd0, d0);
    sample_channel(2'd1, d1);
    sample_channel(2'd2, d2);
    sample_channel(2'd3, d3);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_req"}, adc_req, 0);
    check_output({tag, "_ch"}, adc_ch, 0);
    check_motors(tag, 2'b00, 2'b00);
    check_output({tag, "_busy"}, busy, 0);
    check_output({tag, "_locked"}, locked, 0);
    check_output({tag, "_err"}, adc_err, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    apply_stimulus(1'b0, 1'b0, 16'd0);
    #2;
    check_reset_values("reset");

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    tick();
    check_output("idle_busy", busy, 0);
    check_output("idle_req", adc_req, 0);

    // Balanced: diffs 4 and 5 are within the deadband.
    $display("[TB] balanced scene");
    apply_stimulus(1'b1, 1'b0, 16'd0);
    tick();
    check_output("start_busy", busy, 1);
    sample_four(16'd1000, 16'd1004, 16'd2000, 16'd1995);
    check_output("eval_busy", busy, 1);
    tick();
    check_output("bal_locked", locked, 1);
    check_output("bal_resample_req", adc_req, 1);
    check_output("bal_resample_ch", adc_ch, 0);
    check_motors("bal", 2'b00, 2'b00);

    // Enable drop with a request pending: waits for ack, then idles with locked held.
    $display("[TB] enable drop during sample");
    apply_stimulus(1'b0, 1'b0, 16'd0);
    tick();
    check_output("drop_pending_req", adc_req, 1);
    check_output("drop_pending_busy", busy, 1);
    apply_stimulus(1'b0, 1'b1, 16'd123);
    tick();
    apply_stimulus(1'b0, 1'b0, 16'd0);
    check_output("drop_idle_busy", busy, 0);
    check_output("drop_idle_req", adc_req, 0);
    check_output("drop_locked_hold", locked, 1);
    apply_stimulus(1'b1, 1'b0, 16'd0);
    tick();
    check_output("restart_req", adc_req, 1);

    // Vertical only: 1200 > 1000 gives clockwise.
    $display("[TB] vertical only scene");
    sample_four(16'd1200, 16'd1000, 16'd500, 16'd500);
    tick();
    check_output("vert_locked", locked, 0);
    for (int i = 0; i < 4; i++) begin
      check_motors($sformatf("vert_move%0d", i), 2'b01, 2'b00);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      check_motors($sformatf("vert_settle%0d", i), 2'b00, 2'b00);
      check_output($sformatf("vert_settle_req%0d", i), adc_req, 0);
      tick();
    end
    check_output("vert_resample_req", adc_req, 1);
    check_output("vert_resample_ch", adc_ch, 0);

    // Both axes with extreme readings: no wrap may fake a balance.
    $display("[TB] both axes scene");
    sample_four(16'd10, 16'd9000, 16'd65535, 16'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      check_motors($sformatf("both_t%0d", i), 2'b11, 2'b00);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      check_motors($sformatf("both_p%0d", i), 2'b00, 2'b01);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      check_motors($sformatf("both_settle%0d", i), 2'b00, 2'b00);
      tick();
    end
    check_output("both_resample_req", adc_req, 1);

    // Horizontal only, then enable drops mid MOVE_P.
    $display("[TB] enable drop during horizontal move");
    sample_four(16'd500, 16'd500, 16'd100, 16'd900);
    tick();
    check_motors("hmove0", 2'b00, 2'b11);
    tick();
    check_motors("hmove1", 2'b00, 2'b11);
    apply_stimulus(1'b0, 1'b0, 16'd0);
    tick();
    check_motors("hdrop", 2'b00, 2'b00);
    check_output("hdrop_busy", busy, 0);

    // Timeout on channel 2: request stays up 8 cycles, then sticky error.
    $display("[TB] ack timeout scene");
    apply_stimulus(1'b1, 1'b0, 16'd0);
    tick();
    sample_channel(2'd0, 16'd100);
    sample_channel(2'd1, 16'd100);
    tick();
    check_output("to_req_ch", adc_ch, 2);
    check_output("to_wait0_req", adc_req, 1);
    check_output("to_wait0_err", adc_err, 0);
    for (int i = 1; i < 8; i++) begin
      tick();
      check_output($sformatf("to_wait%0d_req", i), adc_req, 1);
      check_output($sformatf("to_wait%0d_err", i), adc_err, 0);
    end
    tick();
    check_output("to_err", adc_err, 1);
    check_output("to_req_low", adc_req, 0);
    check_output("to_busy", busy, 0);
    check_output("to_locked", locked, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output($sformatf("to_stay_idle%0d", i), busy, 0);
      check_output($sformatf("to_sticky%0d", i), adc_err, 1);
    end
    apply_stimulus(1'b0, 1'b0, 16'd0);
    tick();
    apply_stimulus(1'b1, 1'b0, 16'd0);
    tick();
    check_output("to_err_cleared", adc_err, 0);
    check_output("to_clear_busy", busy, 0);
    tick();
    check_output("to_restart_busy", busy, 1);
    check_output("to_restart_req", adc_req, 1);
    check_output("to_restart_ch", adc_ch, 0);

    // Asynchronous reset in the middle of a vertical move.
    $display("[TB] reset during vertical move");
    sample_four(16'd1200, 16'd1000, 16'd500, 16'd500);
    tick();
    tick();
    check_motors("pre_reset", 2'b01, 2'b00);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
